// File: rtl/branch_target_buffer_fsm.sv
// 2-bit saturating direction-predictor update for one BTB entry.
// Registered next-state of the presented predictor; no per-entry storage.
`timescale 1ns/1ps

module branch_target_buffer_fsm (
  input  logic       btb_fsm_clk,
  input  logic       btb_fsm_reset_n,
  input  logic       btb_fsm_branch_taken,
  input  logic [1:0] btb_fsm_current_prediction,
  output logic [1:0] btb_fsm_new_prediction,
  output logic       btb_fsm_predict_taken
);

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pred_e;

  pred_e pred_q;

  // Next state comes from the entry's stored value, not from pred_q; the
  // default also catches an uninitialised (X) entry and parks it at WNT.
  always_ff @(posedge btb_fsm_clk or negedge btb_fsm_reset_n) begin
    if (!btb_fsm_reset_n) begin
      pred_q <= WNT;
    end else begin
      case (btb_fsm_current_prediction)
        SNT:     pred_q <= btb_fsm_branch_taken ? WNT : SNT;
        WNT:     pred_q <= btb_fsm_branch_taken ? WT  : SNT;
        WT:      pred_q <= btb_fsm_branch_taken ? ST  : WNT;
        ST:      pred_q <= btb_fsm_branch_taken ? ST  : WT;
        default: pred_q <= WNT;
      endcase
    end
  end

  assign btb_fsm_new_prediction = pred_q;
  assign btb_fsm_predict_taken  = pred_q[1];

endmodule

// File: tb/tb_branch_target_buffer_fsm.sv
// Scoreboarded bench for branch_target_buffer_fsm: directed plan, then random.
`timescale 1ns/1ps

module tb_branch_target_buffer_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       taken = 1'b0;
  logic [1:0] cur = 2'b00;
  logic [1:0] new_pred;
  logic       pred_taken;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [1:0]  sb[$];
  logic [1:0]  prev_exp = 2'b01;

  branch_target_buffer_fsm dut (
    .btb_fsm_clk                (clk),
    .btb_fsm_reset_n            (rst_n),
    .btb_fsm_branch_taken       (taken),
    .btb_fsm_current_prediction (cur),
    .btb_fsm_new_prediction     (new_pred),
    .btb_fsm_predict_taken      (pred_taken)
  );

  always #5 clk = ~clk;

  // Reference: counter moves one step toward the outcome, clamped to 0..3.
  function automatic logic [1:0] ref_next(input logic [1:0] c, input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b at %0t", name, got, want, $time);
    end
  endtask

  // Drive inputs mid-cycle, confirm the output has not moved, queue the result.
  task automatic drive(input logic [1:0] c, input logic t);
    logic [1:0] e;
    @(negedge clk);
    cur   = c;
    taken = t;
    #1;
    chk("hold", new_pred, prev_exp);
    e = rst_n ? ref_next(c, t) : 2'b01;
    sb.push_back(e);
    prev_exp = e;
  endtask

  // Assert reset shortly before the coming edge, cancelling the queued update.
  task automatic reset_before_edge();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", new_pred, 2'b01);
    chk("async_reset_pt", {1'b0, pred_taken}, 2'b00);
    if (sb.size() > 0) sb[sb.size()-1] = 2'b01;
    prev_exp = 2'b01;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    logic [1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pred", new_pred, e);
        chk("predict_taken", {1'b0, pred_taken}, {1'b0, e[1]});
      end
    end
  end

  initial begin : stim
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_now", new_pred, 2'b01);
    chk("reset_now_pt", {1'b0, pred_taken}, 2'b00);

    drive(2'b11, 1'b1);
    drive(2'b10, 1'b0);
    drive(2'b00, 1'b1);
    release_reset();

    drive(2'b00, 1'b1);
    drive(2'b01, 1'b1);
    drive(2'b10, 1'b1);
    repeat (3) drive(2'b11, 1'b1);
    drive(2'b11, 1'b0);
    drive(2'b10, 1'b0);
    drive(2'b01, 1'b0);
    drive(2'b00, 1'b0);

    drive(2'b00, 1'b1);
    drive(2'b11, 1'b0);

    drive(2'b10, 1'b1);
    reset_before_edge();
    release_reset();
    drive(2'b10, 1'b1);

    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 19) == 0) begin
        reset_before_edge();
        for (int j = 0; j < int'($urandom_range(0, 2)); j++)
          drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        release_reset();
      end
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 2'(sb.size() > 0 ? 1 : 0), 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
